// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with NZCV flags and an iterative shift-add multiplier
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags,
  output logic             busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_BIC = 3'b110;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic             in_fire;
  logic             is_mul;
  logic             last_iter;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  assign in_fire   = in_valid && in_ready;
  assign is_mul    = (ALUControl == OP_MUL);
  assign last_iter = (count == CNT_W'(WIDTH - 1));

  // The final iteration's partial product is folded in on the same edge that publishes the result
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  // Shared adder: SUB is a + ~b + 1, so the carry out means "no borrow"
  assign b_op = ALUControl[0] ? ~b : b;
  assign sum  = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, ALUControl[0]};

  // Single-cycle result and carry/overflow for every non-multiply encoding
  always_comb begin
    alu_res = sum[WIDTH-1:0];
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALUControl)
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ ALUControl[0]) & (a[WIDTH-1] ^ sum[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_ORR:  alu_res = a | b;
      OP_EOR:  alu_res = a ^ b;
      OP_MUL:  alu_res = '0;
      OP_BIC:  alu_res = a & ~b;
      default: alu_res = b;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: only an accepted MUL leaves IDLE, and it returns after WIDTH iterations
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (in_fire && is_mul) state_next = S_MUL;
      S_MUL:   if (last_iter) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake outputs: accept only when idle and the output slot is free or draining
  always_comb begin
    in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    busy     = (state == S_MUL);
  end

  // Datapath: result/flag registers, output valid and the multiplier iteration state
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      Result    <= '0;
      ALUFlags  <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (state == S_IDLE) begin
        if (in_fire) begin
          if (is_mul) begin
            mcand     <= a;
            mplier    <= b;
            acc       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
          end else begin
            Result    <= alu_res;
            ALUFlags  <= {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
            out_valid <= 1'b1;
          end
        end
      end else begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + CNT_W'(1);
        if (last_iter) begin
          Result    <= acc_next;
          ALUFlags  <= {acc_next[WIDTH-1], (acc_next == '0), 2'b00};
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq at WIDTH=32 and WIDTH=8
module tb_alu_seq;

  typedef struct packed {
    logic [63:0] res;
    logic [3:0]  fl;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  op = '0;

  logic        in_ready32, out_valid32, busy32;
  logic [31:0] result32;
  logic [3:0]  flags32;
  logic        in_ready8, out_valid8, busy8;
  logic [7:0]  result8;
  logic [3:0]  flags8;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
    .a(a), .b(b), .ALUControl(op), .out_valid(out_valid32), .out_ready(out_ready),
    .Result(result32), .ALUFlags(flags32), .busy(busy32)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a[7:0]), .b(b[7:0]), .ALUControl(op), .out_valid(out_valid8), .out_ready(out_ready),
    .Result(result8), .ALUFlags(flags8), .busy(busy8)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Reference: plain wide arithmetic, unsigned compare for borrow, sign comparison for overflow
  function automatic exp_t ref_model(input int w, input logic [2:0] code,
                                     input logic [63:0] x_in, input logic [63:0] y_in);
    logic [63:0] mask, x, y, r;
    logic c, v, sx, sy;
    exp_t e;
    mask = (64'd1 << w) - 64'd1;
    x = x_in & mask;
    y = y_in & mask;
    sx = x[w-1];
    sy = y[w-1];
    c = 1'b0;
    v = 1'b0;
    case (code)
      3'd0: begin r = x + y; c = r[w]; r = r & mask; v = (sx == sy) && (r[w-1] != sx); end
      3'd1: begin r = (x - y) & mask; c = (x >= y); v = (sx != sy) && (r[w-1] != sx); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = (x * y) & mask;
      3'd6: r = x & ~y;
      default: r = y;
    endcase
    e.res = r;
    e.fl = {r[w-1], (r == 64'd0), c, v};
    return e;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hffff_ffff;
      2: return 32'h8000_0080;
      3: return 32'h7fff_ff7f;
      4: return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL reset_out_valid32: got %b exp 0", out_valid32); end
    checks++; if (result32 !== 32'h0) begin errors++; $display("FAIL reset_result32: got %h exp 0", result32); end
    checks++; if (flags32 !== 4'h0) begin errors++; $display("FAIL reset_flags32: got %b exp 0000", flags32); end
    checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL reset_busy32: got %b exp 0", busy32); end
    checks++; if (out_valid8 !== 1'b0 || result8 !== 8'h0) begin errors++; $display("FAIL reset_dut8: got valid %b result %h exp 0 00", out_valid8, result8); end
    reset = 1'b0;
    #1;
    checks++; if (in_ready32 !== 1'b1 || in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b %b exp 1 1", in_ready32, in_ready8); end
  endtask

  task automatic test_add_sub();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; op = 3'd0; a = 32'h7fff_ffff; b = 32'h1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid32 !== 1'b1) begin errors++; $display("FAIL add_valid: got %b exp 1", out_valid32); end
    checks++; if (result32 !== 32'h8000_0000) begin errors++; $display("FAIL add_result: got %h exp 80000000", result32); end
    checks++; if (flags32 !== 4'b1001) begin errors++; $display("FAIL add_flags: got %b exp 1001", flags32); end
    in_valid = 1'b1; op = 3'd1; a = 32'd5; b = 32'd5;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (result32 !== 32'h0 || out_valid32 !== 1'b1) begin errors++; $display("FAIL sub_result: got %h valid %b exp 0 1", result32, out_valid32); end
    checks++; if (flags32 !== 4'b0110) begin errors++; $display("FAIL sub_flags: got %b exp 0110", flags32); end
  endtask

  task automatic test_mul32();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; op = 3'd5; a = 32'h0000_ffff; b = 32'h0001_0001;
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 0; n < 32; n++) begin
      checks++; if (out_valid32 !== 1'b0 || busy32 !== 1'b1 || in_ready32 !== 1'b0) begin
        errors++; $display("FAIL mul32_busy_%0d: got valid %b busy %b in_ready %b exp 0 1 0", n, out_valid32, busy32, in_ready32);
      end
      in_valid = 1'($urandom); op = 3'($urandom); a = $urandom; b = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (out_valid32 !== 1'b1 || busy32 !== 1'b0) begin errors++; $display("FAIL mul32_done: got valid %b busy %b exp 1 0", out_valid32, busy32); end
    checks++; if (result32 !== 32'hffff_ffff) begin errors++; $display("FAIL mul32_result: got %h exp ffffffff", result32); end
    checks++; if (flags32 !== 4'b1000) begin errors++; $display("FAIL mul32_flags: got %b exp 1000", flags32); end
  endtask

  task automatic test_mul8_sub8();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; op = 3'd5; a = 32'h10; b = 32'h10;
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 0; n < 8; n++) begin
      checks++; if (out_valid8 !== 1'b0 || busy8 !== 1'b1) begin errors++; $display("FAIL mul8_busy_%0d: got valid %b busy %b exp 0 1", n, out_valid8, busy8); end
      @(negedge clk);
    end
    checks++; if (out_valid8 !== 1'b1 || result8 !== 8'h00 || flags8 !== 4'b0100) begin
      errors++; $display("FAIL mul8_result: got valid %b result %h flags %b exp 1 00 0100", out_valid8, result8, flags8);
    end
    in_valid = 1'b1; op = 3'd1; a = 32'h0; b = 32'h1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (result8 !== 8'hff || flags8 !== 4'b1000) begin errors++; $display("FAIL sub8_result: got %h flags %b exp ff 1000", result8, flags8); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd0; a = 32'd10; b = 32'd20;
    @(negedge clk);
    op = 3'd3; a = 32'hf0f0_0000; b = 32'h0000_0f0f;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++; if (out_valid32 !== 1'b1 || result32 !== 32'd30 || in_ready32 !== 1'b0) begin
        errors++; $display("FAIL bp_hold_%0d: got valid %b result %h in_ready %b exp 1 0000001e 0", n, out_valid32, result32, in_ready32);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready32 !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b exp 1", in_ready32); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid32 !== 1'b1 || result32 !== 32'hf0f0_0f0f || flags32 !== 4'b1000) begin
      errors++; $display("FAIL bp_orr: got valid %b result %h flags %b exp 1 f0f00f0f 1000", out_valid32, result32, flags32);
    end
    @(negedge clk);
    checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b exp 0", out_valid32); end
  endtask

  task automatic test_reset_mid_mul();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; op = 3'd0; a = 32'd7; b = 32'd8;
    @(negedge clk);
    checks++; if (result32 !== 32'd15) begin errors++; $display("FAIL rmm_pre_add: got %h exp 0000000f", result32); end
    op = 3'd5; a = $urandom; b = $urandom;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (busy32 !== 1'b1) begin errors++; $display("FAIL rmm_busy: got %b exp 1", busy32); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (out_valid32 !== 1'b0 || result32 !== 32'h0 || busy32 !== 1'b0 || flags32 !== 4'h0) begin
      errors++; $display("FAIL rmm_cleared: got valid %b result %h busy %b flags %b exp 0 0 0 0", out_valid32, result32, busy32, flags32);
    end
    reset = 1'b0;
    #1;
    checks++; if (in_ready32 !== 1'b1) begin errors++; $display("FAIL rmm_in_ready: got %b exp 1", in_ready32); end
    in_valid = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid32 !== 1'b1 || result32 !== 32'd5 || flags32 !== 4'b0000) begin
      errors++; $display("FAIL rmm_add: got valid %b result %h flags %b exp 1 00000005 0000", out_valid32, result32, flags32);
    end
  endtask

  task automatic test_random(input int n);
    exp_t q32[$];
    exp_t q8[$];
    exp_t e;
    int i;
    bit drained;
    do_reset();
    i = 0;
    drained = 1'b0;
    while (i < n + 300 && !drained) begin
      @(negedge clk);
      if (i < n) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        op        = 3'($urandom);
        a         = pick_operand();
        b         = pick_operand();
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      if (out_valid32 && out_ready) begin
        checks++;
        if (q32.size() == 0) begin
          errors++; $display("FAIL rand32_extra: unexpected result %h", result32);
        end else begin
          e = q32.pop_front();
          if (result32 !== e.res[31:0] || flags32 !== e.fl) begin
            errors++; $display("FAIL rand32: got %h/%b exp %h/%b", result32, flags32, e.res[31:0], e.fl);
          end
        end
      end
      if (out_valid8 && out_ready) begin
        checks++;
        if (q8.size() == 0) begin
          errors++; $display("FAIL rand8_extra: unexpected result %h", result8);
        end else begin
          e = q8.pop_front();
          if (result8 !== e.res[7:0] || flags8 !== e.fl) begin
            errors++; $display("FAIL rand8: got %h/%b exp %h/%b", result8, flags8, e.res[7:0], e.fl);
          end
        end
      end
      if (in_valid && in_ready32) q32.push_back(ref_model(32, op, {32'b0, a}, {32'b0, b}));
      if (in_valid && in_ready8) q8.push_back(ref_model(8, op, {56'b0, a[7:0]}, {56'b0, b[7:0]}));
      if (i >= n && q32.size() == 0 && q8.size() == 0) drained = 1'b1;
      i++;
    end
    checks++; if (q32.size() != 0) begin errors++; $display("FAIL rand32_lost: %0d results outstanding exp 0", q32.size()); end
    checks++; if (q8.size() != 0) begin errors++; $display("FAIL rand8_lost: %0d results outstanding exp 0", q8.size()); end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul32();
    test_mul8_sub8();
    test_backpressure();
    test_reset_mid_mul();
    test_random(12000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
